// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Hazard/stall controller for the 5-stage pipeline: load-use,
//            MEM-resolved redirects, data-memory handshake with timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
    parameter int DMEM_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             de_mem_read,
    input  logic [4:0]       de_dst_reg,
    input  logic             em_branch,
    input  logic             em_alu_result_zero,
    input  logic             em_jmp,
    input  logic             em_alu_result_to_pc,
    input  logic             em_mem_read,
    input  logic             em_mem_write,
    input  logic             dmem_ack,
    output logic             pc_wren,
    output logic             fd_wren,
    output logic             de_wren,
    output logic             em_wren,
    output logic             mw_wren,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             redirect,
    output logic             dmem_req,
    output logic             err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    localparam logic [7:0]       c_TIMEOUT = 8'(DMEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_nxt;
    logic [7:0]       w_wait_inc;
    logic             r_err;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_access;
    logic w_mem_stall;
    logic w_taken;
    logic w_load_use;

    assign w_access    = em_mem_read | em_mem_write;
    assign w_mem_stall = w_access & ~dmem_ack;
    assign w_taken     = (em_branch & em_alu_result_zero) | em_jmp | em_alu_result_to_pc;
    assign w_load_use  = de_mem_read && (de_dst_reg != 5'd0) &&
                         ((de_dst_reg == id_rs) || (id_uses_rt && (de_dst_reg == id_rt)));
    // wait_cnt after counting the current WAIT cycle
    assign w_wait_inc  = r_wait_cnt + 8'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        pc_wren        = 1'b0;
        fd_wren        = 1'b0;
        de_wren        = 1'b0;
        em_wren        = 1'b0;
        mw_wren        = 1'b0;
        fd_flush       = 1'b0;
        de_flush       = 1'b0;
        em_flush       = 1'b0;
        redirect       = 1'b0;
        dmem_req       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_mem_stall) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = 8'd0;
                end
            end
            S_WAIT: begin
                if (w_access && dmem_ack) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_wait_cnt_nxt = w_wait_inc;
                    if (w_wait_inc == c_TIMEOUT) begin
                        w_state_nxt = S_ERROR;
                    end
                end
            end
            S_ERROR: begin
                w_state_nxt = S_ERROR;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (!reset && (r_state != S_ERROR)) begin
            dmem_req = w_access;
            if (!w_mem_stall) begin
                // Redirect flush wins over a concurrent load-use bubble
                if (w_taken) begin
                    pc_wren  = 1'b1;
                    fd_wren  = 1'b1;
                    de_wren  = 1'b1;
                    em_wren  = 1'b1;
                    mw_wren  = 1'b1;
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                    em_flush = 1'b1;
                    redirect = 1'b1;
                end else if (w_load_use) begin
                    de_wren  = 1'b1;
                    em_wren  = 1'b1;
                    mw_wren  = 1'b1;
                    de_flush = 1'b1;
                end else begin
                    pc_wren  = 1'b1;
                    fd_wren  = 1'b1;
                    de_wren  = 1'b1;
                    em_wren  = 1'b1;
                    mw_wren  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 8'd0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_err      <= r_err | (w_state_nxt == S_ERROR);
            if (!pc_wren && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign err          = r_err;
    assign stall_cycles = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed + randomized bench for pipeline_ctrl against a
//            behavioural model; two instances with different parameters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, de_dst_reg;
    logic       id_uses_rt, de_mem_read;
    logic       em_branch, em_alu_result_zero, em_jmp, em_alu_result_to_pc;
    logic       em_mem_read, em_mem_write, dmem_ack;

    logic a_pc, a_fd, a_de, a_em, a_mw, a_fdf, a_def, a_emf, a_rd, a_req, a_err;
    logic b_pc, b_fd, b_de, b_em, b_mw, b_fdf, b_def, b_emf, b_rd, b_req, b_err;
    logic [3:0]  cnt_a;
    logic [31:0] cnt_b;

    always #5 clk = ~clk;

    pipeline_ctrl #(.DMEM_TIMEOUT(4), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .de_mem_read(de_mem_read), .de_dst_reg(de_dst_reg), .em_branch(em_branch),
        .em_alu_result_zero(em_alu_result_zero), .em_jmp(em_jmp),
        .em_alu_result_to_pc(em_alu_result_to_pc), .em_mem_read(em_mem_read),
        .em_mem_write(em_mem_write), .dmem_ack(dmem_ack),
        .pc_wren(a_pc), .fd_wren(a_fd), .de_wren(a_de), .em_wren(a_em), .mw_wren(a_mw),
        .fd_flush(a_fdf), .de_flush(a_def), .em_flush(a_emf), .redirect(a_rd),
        .dmem_req(a_req), .err(a_err), .stall_cycles(cnt_a)
    );

    pipeline_ctrl dut_b (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .de_mem_read(de_mem_read), .de_dst_reg(de_dst_reg), .em_branch(em_branch),
        .em_alu_result_zero(em_alu_result_zero), .em_jmp(em_jmp),
        .em_alu_result_to_pc(em_alu_result_to_pc), .em_mem_read(em_mem_read),
        .em_mem_write(em_mem_write), .dmem_ack(dmem_ack),
        .pc_wren(b_pc), .fd_wren(b_fd), .de_wren(b_de), .em_wren(b_em), .mw_wren(b_mw),
        .fd_flush(b_fdf), .de_flush(b_def), .em_flush(b_emf), .redirect(b_rd),
        .dmem_req(b_req), .err(b_err), .stall_cycles(cnt_b)
    );

    // {pc, fd, de, em, mw, fd_flush, de_flush, em_flush, redirect, dmem_req, err}
    logic [10:0] w_out_a, w_out_b;
    assign w_out_a = {a_pc, a_fd, a_de, a_em, a_mw, a_fdf, a_def, a_emf, a_rd, a_req, a_err};
    assign w_out_b = {b_pc, b_fd, b_de, b_em, b_mw, b_fdf, b_def, b_emf, b_rd, b_req, b_err};

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    int    m_timeout [2] = '{4, 255};
    longint m_max    [2] = '{15, 64'hFFFF_FFFF};
    bit    m_err     [2];
    bit    m_waiting [2];
    int    m_waited  [2];
    longint m_cnt    [2];

    logic [10:0] s_a, s_b;
    logic [63:0] s_cnt_a, s_cnt_b;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [10:0] model_out(input int k);
        bit acc, tk, lu;
        acc = em_mem_read | em_mem_write;
        tk  = (em_branch & em_alu_result_zero) | em_jmp | em_alu_result_to_pc;
        lu  = de_mem_read && de_dst_reg != 0 &&
              (de_dst_reg == id_rs || (id_uses_rt && de_dst_reg == id_rt));
        if (reset)           return {10'b0, m_err[k]};
        if (m_err[k])        return 11'b000_0000_0001;
        if (acc && !dmem_ack) return 11'b000_0000_0010;
        if (tk)              return {5'b11111, 3'b111, 1'b1, acc, 1'b0};
        if (lu)              return {5'b00111, 3'b010, 1'b0, acc, 1'b0};
        return {5'b11111, 3'b000, 1'b0, acc, 1'b0};
    endfunction

    task automatic model_step(input int k, input bit pc_wren_exp);
        bit acc;
        acc = em_mem_read | em_mem_write;
        if (reset) begin
            m_err[k] = 0; m_waiting[k] = 0; m_waited[k] = 0; m_cnt[k] = 0;
        end else begin
            if (!pc_wren_exp && m_cnt[k] < m_max[k]) m_cnt[k]++;
            if (!m_err[k] && acc) begin
                if (dmem_ack) begin
                    m_waiting[k] = 0;
                end else if (!m_waiting[k]) begin
                    m_waiting[k] = 1;
                    m_waited[k]  = 0;
                end else begin
                    m_waited[k]++;
                    if (m_waited[k] == m_timeout[k]) begin
                        m_err[k] = 1;
                        m_waiting[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        logic [10:0] ea, eb;
        @(negedge clk);
        ea = model_out(0);
        eb = model_out(1);
        s_a = w_out_a; s_b = w_out_b;
        s_cnt_a = 64'(cnt_a); s_cnt_b = 64'(cnt_b);
        check_val("outs_a", 64'(w_out_a), 64'(ea));
        check_val("cnt_a", 64'(cnt_a), 64'(m_cnt[0]));
        check_val("outs_b", 64'(w_out_b), 64'(eb));
        check_val("cnt_b", 64'(cnt_b), 64'(m_cnt[1]));
        @(posedge clk);
        model_step(0, ea[10]);
        model_step(1, eb[10]);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; de_mem_read = 0; de_dst_reg = 0;
        em_branch = 0; em_alu_result_zero = 0; em_jmp = 0; em_alu_result_to_pc = 0;
        em_mem_read = 0; em_mem_write = 0; dmem_ack = 0;
    endtask

    initial begin
        logic [63:0] base;
        bit hold;
        for (int k = 0; k < 2; k++) begin
            m_err[k] = 0; m_waiting[k] = 0; m_waited[k] = 0; m_cnt[k] = 0;
        end
        clear_inputs();
        @(posedge clk); #1;

        reset = 1;
        cycle();
        check_val("rst_outs", 64'(s_a), 64'd0);
        reset = 0;
        cycle();
        check_val("rst_cnt", s_cnt_a, 64'd0);
        check_val("normal", 64'(s_a), 64'(11'b11111_000_0_0_0));

        // Load-use on rs, then the r0 case
        de_mem_read = 1; de_dst_reg = 5; id_rs = 5;
        cycle();
        check_val("lu_outs", 64'(s_a), 64'(11'b00111_010_0_0_0));
        de_dst_reg = 0; id_rs = 0;
        cycle();
        check_val("lu_cnt", s_cnt_a, 64'd1);
        check_val("lu_r0", 64'(s_a), 64'(11'b11111_000_0_0_0));

        // Taken branch with a simultaneous load-use hazard
        de_dst_reg = 7; id_rt = 7; id_uses_rt = 1; em_branch = 1; em_alu_result_zero = 1;
        cycle();
        check_val("br_outs", 64'(s_a), 64'(11'b11111_111_1_0_0));
        clear_inputs();
        cycle();
        check_val("br_cnt", s_cnt_a, 64'd1);

        // Three-wait read
        base = s_cnt_a;
        em_mem_read = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("mw_stall", 64'(s_a), 64'(11'b00000_000_0_1_0));
        end
        dmem_ack = 1;
        cycle();
        check_val("mw_done", 64'(s_a), 64'(11'b11111_000_0_1_0));
        clear_inputs();
        cycle();
        check_val("mw_cnt", s_cnt_a, base + 64'd3);

        // Zero-wait write, then an idle cycle must not stall
        em_mem_write = 1; dmem_ack = 1;
        cycle();
        check_val("zw_outs", 64'(s_a), 64'(11'b11111_000_0_1_0));
        clear_inputs();
        cycle();
        check_val("zw_idle", 64'(s_a), 64'(11'b11111_000_0_0_0));

        // Timeout on dut_a (4), dut_b keeps waiting
        em_mem_read = 1;
        for (int i = 0; i < 5; i++) cycle();
        cycle();
        check_val("to_err_a", 64'(s_a), 64'(11'b00000_000_0_0_1));
        check_val("to_wait_b", 64'(s_b), 64'(11'b00000_000_0_1_0));
        reset = 1;
        cycle();
        clear_inputs();
        cycle();
        check_val("to_rst_cnt", s_cnt_a, 64'd0);
        check_val("to_rst_outs", 64'(s_a), 64'(11'b11111_000_0_0_0));

        // Saturation: 20 load-use stall cycles on a 4-bit counter
        de_mem_read = 1; de_dst_reg = 3; id_rs = 3;
        for (int i = 0; i < 20; i++) cycle();
        clear_inputs();
        cycle();
        check_val("sat_a", s_cnt_a, 64'd15);
        check_val("sat_b", s_cnt_b, 64'd20);

        // Randomized traffic; EM fields hold while the EM register is frozen
        reset = 1;
        cycle();
        reset = 0;
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 59) == 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            id_uses_rt  = 1'($urandom);
            de_mem_read = ($urandom_range(0, 2) == 0);
            de_dst_reg  = 5'($urandom_range(0, 3));
            dmem_ack    = ($urandom_range(0, 2) == 0);
            if (!hold) begin
                em_branch           = 1'($urandom);
                em_alu_result_zero  = 1'($urandom);
                em_jmp              = ($urandom_range(0, 7) == 0);
                em_alu_result_to_pc = ($urandom_range(0, 7) == 0);
                em_mem_read         = ($urandom_range(0, 3) == 0);
                em_mem_write        = ($urandom_range(0, 3) == 0);
            end
            cycle();
            hold = !(s_a[7] && s_b[7]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and stall controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It drives the `wren` enables of the PC and the four stage registers and requests bubble insertion from the stage register input muxes. It covers three cases: load-use hazards, taken branches and jumps resolved in MEM, and a multi-cycle data-memory req/ack handshake with timeout. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- `DMEM_TIMEOUT`, default 255: maximum number of cycles to wait for `dmem_ack` before entering ERROR (range 1..255).
- `CNT_W`, default 32: width of `stall_cycles`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `id_rs`  in  5  rs field of the instruction in ID (FD register output).
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rt`  in  1  the ID instruction reads rt.
- `de_mem_read`  in  1  DE-register `dec_mem_read`.
- `de_dst_reg`  in  5  DE-register `dst_reg`.
- `em_branch`  in  1  EM-register `dec_branch`.
- `em_alu_result_zero`  in  1  EM-register `alu_result_zero`.
- `em_jmp`  in  1  EM-register `dec_jmp`.
- `em_alu_result_to_pc`  in  1  EM-register `dec_alu_result_to_pc` (register jump).
- `em_mem_read`  in  1  EM-register `dec_mem_read`.
- `em_mem_write`  in  1  EM-register `dec_mem_write`.
- `dmem_ack`  in  1  data memory completion; valid only while `dmem_req`=1.
- `pc_wren`  out  1  PC enable.
- `fd_wren`  out  1  FD register enable.
- `de_wren`  out  1  DE register enable.
- `em_wren`  out  1  EM register enable.
- `mw_wren`  out  1  MW register enable.
- `fd_flush`  out  1  load a NOP into FD at the next edge.
- `de_flush`  out  1  load zeroed control bits into DE at the next edge.
- `em_flush`  out  1  load zeroed control bits into EM at the next edge.
- `redirect`  out  1  PC mux selects the MEM-stage target instead of PC+4.
- `dmem_req`  out  1  data memory access request.
- `err`  out  1  sticky memory-timeout error.
- `stall_cycles`  out  CNT_W  count of cycles with `pc_wren`=0, saturating.

## Operation
- Memory FSM states:
  - IDLE → WAIT when `em_mem_read|em_mem_write` and `dmem_ack`=0.
  - In IDLE, an access with `dmem_ack`=1 in the same cycle is a zero-wait access and stays in IDLE.
  - WAIT → IDLE on `dmem_ack`.
  - WAIT → ERROR when `wait_cnt` = DMEM_TIMEOUT and `dmem_ack`=0.
  - ERROR is left only by `reset`.
- `wait_cnt` (8 bits): cleared on entry to WAIT, incremented each WAIT cycle.
- `dmem_req` = access present in EM, state ≠ ERROR.
- Priority, highest first; exactly one case applies per cycle:
  1. **ERROR**: all wren=0, all flush=0, `redirect`=0, `dmem_req`=0, `err`=1.
  2. **mem_stall** (access present and `dmem_ack`=0): all five wren=0, all flush=0, `redirect`=0.
  3. **redirect** (taken = `(em_branch & em_alu_result_zero) | em_jmp | em_alu_result_to_pc`): all wren=1, `redirect`=1, `fd_flush`=`de_flush`=`em_flush`=1. This flush overrides any concurrent load-use hazard.
  4. **load_use** (`de_mem_read` & `de_dst_reg`≠0 & (`de_dst_reg`=`id_rs` | (`id_uses_rt` & `de_dst_reg`=`id_rt`))): `pc_wren`=`fd_wren`=0, `de_wren`=1 with `de_flush`=1, `em_wren`=`mw_wren`=1.
  5. **normal**: all wren=1, all flush=0.
- `stall_cycles`: increments on every cycle where `pc_wren`=0, including ERROR; holds at 2^CNT_W−1.
- Register r0 never triggers a hazard.

## Timing
- All control outputs are combinational from the current state and inputs; they act on the same rising edge.
- FSM state, `wait_cnt`, `err` and `stall_cycles` are registered.
- Zero-wait access: `dmem_req` and `dmem_ack` high in the same cycle; the pipeline advances at that edge with no stall.
- N-wait access: the pipeline is frozen for N cycles and advances on the edge where `dmem_ack`=1.
  - `dmem_req` stays high continuously until then.
  - `dmem_req` drops the cycle after the ack unless the next EM instruction is also an access.
- Redirect penalty: 3 bubbles (FD, DE, EM); the target instruction is fetched the cycle after `redirect`.
- Load-use penalty: 1 bubble; the hazard clears once the load moves to EM.
- Timeout: ERROR is entered on the edge after the DMEM_TIMEOUT-th WAIT cycle without ack. `err` rises that cycle and stays high.
- `dmem_ack` seen while `dmem_req`=0 is ignored.
- Reset, taking priority over everything:
  - State→IDLE, `wait_cnt`=0, `err`=0, `stall_cycles`=0.
  - While `reset`=1: all wren=0, all flush=0, `redirect`=0, `dmem_req`=0.
  - Reset during WAIT or ERROR aborts the access, with no ack required afterwards.

## Test plan
- Load-use: `de_mem_read`=1, `de_dst_reg`=5, `id_rs`=5 → one cycle with `pc_wren`=`fd_wren`=0 and `de_flush`=1; `stall_cycles` 0→1. Repeat with `de_dst_reg`=0 → no stall.
- Branch taken: `em_branch`=1, `em_alu_result_zero`=1, with a load-use hazard also present → `redirect`=1, all three flushes=1, all wren=1, `stall_cycles` unchanged.
- Memory wait: `em_mem_read`=1, `dmem_ack` low for 3 cycles then high → all wren=0 for 3 cycles, `dmem_req` high for 4 cycles, advance on the 4th; `stall_cycles`=3.
- Zero-wait: `em_mem_write`=1 with `dmem_ack`=1 in the same cycle → all wren=1 and the FSM stays in IDLE.
- Timeout: DMEM_TIMEOUT=4, `dmem_ack` held low → `err`=1 after 4 WAIT cycles, `dmem_req`=0, all wren=0. Then assert `reset` for 1 cycle → `err`=0, `stall_cycles`=0, normal operation.
- Saturation: CNT_W=4, force 20 stall cycles → `stall_cycles`=15.
